scan_sequencer: RTL and testbench

SCAN_SEQUENCER -- requirements
Module: scan_sequencer

---
 rtl/scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_scan_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer: steps a 2-bit select across the active positions of a
// 4-entry mask, holding each position for dwell+1 cycles. It can scan in
// either direction, either continuously or as a single pass. All outputs
// are registered so the downstream 2-to-4 decoder sees glitch-free signals.
module scan_sequencer #(
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               stop,
   input  logic               dir,
   input  logic               mode,
   input  logic [3:0]         mask,
   input  logic [DWELL_W-1:0] dwell,
   output logic [1:0]         sel,
   output logic               sel_en,
   output logic               busy,
   output logic               wrap,
   output logic               done
);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [DWELL_W-1:0] cnt;
   logic [DWELL_W-1:0] cnt_nxt;
   logic [1:0]         sel_nxt;
   logic               sel_en_nxt;
   logic               busy_nxt;
   logic               wrap_nxt;
   logic               done_nxt;

   logic [1:0]         first_pos;
   logic [1:0]         step_pos;
   logic               step_wraps;
   logic               dwell_hit;
   logic               mask_empty;

   // Starting position of a scan: the lowest active index when ascending,
   // the highest when descending. Later loop iterations override earlier
   // ones, so the iteration order picks the winner.
   function automatic logic [1:0] first_active(input logic [3:0] m, input logic d);
      logic [1:0] r;
      r = 2'd0;
      if (!d) begin
         for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (m[i]) r = 2'(i);
         end
      end
      return r;
   endfunction

   // Next active position after cur, moving in direction d, modulo 4.
   // Distances are tried from farthest to nearest, so the nearest active
   // one wins. If no other position is active, cur itself is the answer.
   // That only happens when cur is the sole active bit, because the caller
   // guarantees the mask is non-zero.
   function automatic logic [1:0] next_active(input logic [1:0] cur,
                                              input logic [3:0] m,
                                              input logic       d);
      logic [1:0] r;
      logic [1:0] cand;
      r = cur;
      for (int k = 3; k >= 1; k--) begin
         cand = d ? (cur - 2'(k)) : (cur + 2'(k));
         if (m[cand]) r = cand;
      end
      return r;
   endfunction

   // Search results and flags derived from the live inputs and current
   // position. A step is a wrap when it fails to move strictly forward in
   // the scan direction.
   always_comb begin
      first_pos  = first_active(mask, dir);
      step_pos   = next_active(sel, mask, dir);
      step_wraps = dir ? (step_pos >= sel) : (step_pos <= sel);
      dwell_hit  = (cnt == dwell);
      mask_empty = (mask == 4'b0000);
   end

   // Next-state and next-output decode. Stop, or an empty mask, takes
   // priority over an advance. A single-pass wrap leaves sel on the last
   // scanned position rather than moving to the wrapped one.
   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      sel_nxt    = sel;
      sel_en_nxt = sel_en;
      busy_nxt   = busy;
      wrap_nxt   = 1'b0;
      done_nxt   = 1'b0;
      case (state)
         IDLE: begin
            sel_en_nxt = 1'b0;
            busy_nxt   = 1'b0;
            cnt_nxt    = '0;
            if (start && !stop && !mask_empty) begin
               state_nxt  = RUN;
               sel_nxt    = first_pos;
               sel_en_nxt = 1'b1;
               busy_nxt   = 1'b1;
            end
         end
         RUN: begin
            if (stop || mask_empty) begin
               state_nxt  = IDLE;
               sel_en_nxt = 1'b0;
               busy_nxt   = 1'b0;
               cnt_nxt    = '0;
            end else if (dwell_hit) begin
               cnt_nxt = '0;
               if (step_wraps) begin
                  wrap_nxt = 1'b1;
                  if (mode) begin
                     state_nxt  = IDLE;
                     sel_en_nxt = 1'b0;
                     busy_nxt   = 1'b0;
                     done_nxt   = 1'b1;
                  end else begin
                     sel_nxt = step_pos;
                  end
               end else begin
                  sel_nxt = step_pos;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt  = IDLE;
            sel_en_nxt = 1'b0;
            busy_nxt   = 1'b0;
            cnt_nxt    = '0;
         end
      endcase
   end

   // State, dwell counter and output registers. Reset is synchronous and
   // overrides every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         sel    <= 2'd0;
         sel_en <= 1'b0;
         busy   <= 1'b0;
         wrap   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         sel    <= sel_nxt;
         sel_en <= sel_en_nxt;
         busy   <= busy_nxt;
         wrap   <= wrap_nxt;
         done   <= done_nxt;
      end
   end

endmodule

// File: tb/tb_scan_sequencer.sv
// tb_scan_sequencer: directed scenarios for scan_sequencer. Each cycle's
// expected outputs are queued as stimulus is applied, then popped and
// compared just after the clock edge.
module tb_scan_sequencer;

   logic       clk;
   logic       rst;
   logic       start;
   logic       stop;
   logic       dir;
   logic       mode;
   logic [3:0] mask;
   logic [7:0] dwell;
   logic [1:0] sel;
   logic       sel_en;
   logic       busy;
   logic       wrap;
   logic       done;

   typedef struct packed {
      logic [1:0] sel;
      logic       en;
      logic       busy;
      logic       wrap;
      logic       done;
   } exp_t;

   exp_t  sb_q[$];
   string tag_q[$];
   int    errors;
   int    checks;

   scan_sequencer #(.DWELL_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .stop   (stop),
      .dir    (dir),
      .mode   (mode),
      .mask   (mask),
      .dwell  (dwell),
      .sel    (sel),
      .sel_en (sel_en),
      .busy   (busy),
      .wrap   (wrap),
      .done   (done)
   );

   // Free-running clock with a 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Guard so the run always ends, even if the stimulus stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Queue the outputs expected after the coming edge, clock once, then pop
   // that entry and compare it against the DUT.
   task automatic applyStimulus(input string tag, input logic [1:0] e_sel,
                                input logic e_en, input logic e_busy,
                                input logic e_wrap, input logic e_done);
      exp_t  e;
      string t;
      sb_q.push_back({e_sel, e_en, e_busy, e_wrap, e_done});
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      checkOutput({t, ".sel"},    {6'b0, sel},    {6'b0, e.sel});
      checkOutput({t, ".sel_en"}, {7'b0, sel_en}, {7'b0, e.en});
      checkOutput({t, ".busy"},   {7'b0, busy},   {7'b0, e.busy});
      checkOutput({t, ".wrap"},   {7'b0, wrap},   {7'b0, e.wrap});
      checkOutput({t, ".done"},   {7'b0, done},   {7'b0, e.done});
   endtask

   // Directed scenarios, each ending back in IDLE.
   initial begin
      logic [1:0] s;
      errors = 0;
      checks = 0;
      rst = 1'b1; start = 1'b0; stop = 1'b0; dir = 1'b0; mode = 1'b0;
      mask = 4'b0000; dwell = 8'd0;
      applyStimulus("reset", 2'd0, 0, 0, 0, 0);
      applyStimulus("reset", 2'd0, 0, 0, 0, 0);
      rst = 1'b0;

      $display("[TB] full mask ascending continuous, dwell 2");
      mask = 4'b1111; dir = 1'b0; mode = 1'b0; dwell = 8'd2; start = 1'b1;
      applyStimulus("asc_entry", 2'd0, 1, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         s = 2'((k / 3) % 4);
         applyStimulus("asc_scan", s, 1, 1, (k == 12), 0);
      end
      stop = 1'b1;
      applyStimulus("asc_stop", 2'd1, 0, 0, 0, 0);
      stop = 1'b0;

      $display("[TB] start together with stop in idle");
      mask = 4'b1111; start = 1'b1; stop = 1'b1;
      applyStimulus("startstop", 2'd1, 0, 0, 0, 0);
      start = 1'b0; stop = 1'b0;
      applyStimulus("startstop_idle", 2'd1, 0, 0, 0, 0);

      $display("[TB] mask 1010 descending single pass, dwell 0");
      mask = 4'b1010; dir = 1'b1; mode = 1'b1; dwell = 8'd0; start = 1'b1;
      applyStimulus("pass_entry", 2'd3, 1, 1, 0, 0);
      start = 1'b0;
      applyStimulus("pass_step", 2'd1, 1, 1, 0, 0);
      applyStimulus("pass_done", 2'd1, 0, 0, 1, 1);
      applyStimulus("pass_idle", 2'd1, 0, 0, 0, 0);

      $display("[TB] single active position, dwell 1");
      mask = 4'b0100; dir = 1'b0; mode = 1'b0; dwell = 8'd1; start = 1'b1;
      applyStimulus("one_entry", 2'd2, 1, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         applyStimulus("one_wrap", 2'd2, 1, 1, (k % 2 == 0), 0);
      end
      stop = 1'b1;
      applyStimulus("one_stop", 2'd2, 0, 0, 0, 0);
      stop = 1'b0;

      $display("[TB] stop on an advance cycle, start held while running");
      mask = 4'b1111; dir = 1'b0; mode = 1'b0; dwell = 8'd0; start = 1'b1;
      applyStimulus("advstop_entry", 2'd0, 1, 1, 0, 0);
      applyStimulus("advstop_run", 2'd1, 1, 1, 0, 0);
      applyStimulus("advstop_run", 2'd2, 1, 1, 0, 0);
      start = 1'b0; stop = 1'b1;
      applyStimulus("advstop_stop", 2'd2, 0, 0, 0, 0);
      stop = 1'b0;
      applyStimulus("advstop_idle", 2'd2, 0, 0, 0, 0);

      $display("[TB] mask cleared while running");
      mask = 4'b1111; dir = 1'b1; dwell = 8'd5; start = 1'b1;
      applyStimulus("mask0_entry", 2'd3, 1, 1, 0, 0);
      start = 1'b0;
      applyStimulus("mask0_run", 2'd3, 1, 1, 0, 0);
      mask = 4'b0000;
      applyStimulus("mask0_stop", 2'd3, 0, 0, 0, 0);

      $display("[TB] mask and dir changes mid-scan");
      mask = 4'b1111; dir = 1'b0; mode = 1'b0; dwell = 8'd1; start = 1'b1;
      applyStimulus("live_entry", 2'd0, 1, 1, 0, 0);
      start = 1'b0;
      applyStimulus("live_k1", 2'd0, 1, 1, 0, 0);
      applyStimulus("live_k2", 2'd1, 1, 1, 0, 0);
      mask = 4'b1001;
      applyStimulus("live_hold", 2'd1, 1, 1, 0, 0);
      applyStimulus("live_skip", 2'd3, 1, 1, 0, 0);
      dir = 1'b1;
      applyStimulus("live_k5", 2'd3, 1, 1, 0, 0);
      applyStimulus("live_down", 2'd0, 1, 1, 0, 0);
      applyStimulus("live_k7", 2'd0, 1, 1, 0, 0);
      applyStimulus("live_wrap", 2'd3, 1, 1, 1, 0);
      stop = 1'b1;
      applyStimulus("live_stop", 2'd3, 0, 0, 0, 0);
      stop = 1'b0;

      $display("[TB] dwell lowered below a running count");
      mask = 4'b0011; dir = 1'b0; mode = 1'b0; dwell = 8'd5; start = 1'b1;
      applyStimulus("roll_entry", 2'd0, 1, 1, 0, 0);
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         applyStimulus("roll_pre", 2'd0, 1, 1, 0, 0);
      end
      dwell = 8'd1;
      for (int k = 4; k <= 258; k++) begin
         s = (k == 258) ? 2'd1 : 2'd0;
         applyStimulus("roll_count", s, 1, 1, 0, 0);
      end
      stop = 1'b1;
      applyStimulus("roll_stop", 2'd1, 0, 0, 0, 0);
      stop = 1'b0;

      $display("[TB] reset mid-dwell, then start with empty mask");
      mask = 4'b1111; dir = 1'b1; dwell = 8'd3; start = 1'b1;
      applyStimulus("rst_entry", 2'd3, 1, 1, 0, 0);
      start = 1'b0;
      applyStimulus("rst_dwell", 2'd3, 1, 1, 0, 0);
      rst = 1'b1; start = 1'b1;
      applyStimulus("rst_clear", 2'd0, 0, 0, 0, 0);
      rst = 1'b0; mask = 4'b0000;
      applyStimulus("rst_mask0", 2'd0, 0, 0, 0, 0);
      start = 1'b0;
      applyStimulus("rst_idle", 2'd0, 0, 0, 0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
